// File: rtl/wilkinson_combiner_if.sv
// wilkinson_combiner_if: branch A/B sample streams and the combined output stream.
// Carries y_diff only when WILKINSON_COMBINER_DIFF_EN is defined.
interface wilkinson_combiner_if #(parameter int DW = 16);
  logic          a_valid, a_ready, b_valid, b_ready, y_valid, y_ready;
  logic [DW-1:0] a_data, b_data, y_sum;
`ifdef WILKINSON_COMBINER_DIFF_EN
  logic [DW-1:0] y_diff;
  modport master (output a_valid, a_data, b_valid, b_data, y_ready,
                  input a_ready, b_ready, y_valid, y_sum, y_diff);
  modport slave  (input a_valid, a_data, b_valid, b_data, y_ready,
                  output a_ready, b_ready, y_valid, y_sum, y_diff);
`else
  modport master (output a_valid, a_data, b_valid, b_data, y_ready,
                  input a_ready, b_ready, y_valid, y_sum);
  modport slave  (input a_valid, a_data, b_valid, b_data, y_ready,
                  output a_ready, b_ready, y_valid, y_sum);
`endif
endinterface

// File: rtl/wilkinson_combiner.sv
// wilkinson_combiner: 2:1 combiner y=(a+b)>>>1 with per-branch realignment FIFOs.
// Define WILKINSON_COMBINER_DIFF_EN to add the y_diff=(a-b)>>>1 isolation output.
module wilkinson_combiner #(
  parameter int DW    = 16,
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH+1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  wilkinson_combiner_if.slave   bus,
  output logic [LW-1:0]         a_level,
  output logic [LW-1:0]         b_level,
  output logic                  skew_err
);
  localparam int PW = $clog2(DEPTH);
  logic [DW-1:0] mem_q [2][DEPTH];
  logic [DW-1:0] din [2];
  logic [PW-1:0] wp_q [2];
  logic [PW-1:0] rp_q [2];
  logic [LW-1:0] lvl_q [2];
  logic [1:0]    push;
  logic          fire;
  logic [DW-1:0] ha, hb;
  logic [DW:0]   sum_w;
  logic          y_valid_q, y_valid_d, skew_q, skew_d;
  logic [DW-1:0] y_sum_q, y_sum_d;
  assign din[0]      = bus.a_data;
  assign din[1]      = bus.b_data;
  assign bus.a_ready = lvl_q[0] != LW'(DEPTH);
  assign bus.b_ready = lvl_q[1] != LW'(DEPTH);
  assign push        = {bus.b_valid && bus.b_ready, bus.a_valid && bus.a_ready};
  assign fire        = (lvl_q[0] != '0) && (lvl_q[1] != '0) && (!y_valid_q || bus.y_ready);
  assign ha          = mem_q[0][rp_q[0]];
  assign hb          = mem_q[1][rp_q[1]];
  // Sign-extend to DW+1 so the halved result cannot overflow; taking [DW:1] is >>>1.
  assign sum_w       = {ha[DW-1], ha} + {hb[DW-1], hb};
  always_comb begin
    y_valid_d = fire || (y_valid_q && !bus.y_ready);
    y_sum_d   = fire ? sum_w[DW:1] : y_sum_q;
    skew_d    = skew_q || (lvl_q[0] == LW'(DEPTH) && lvl_q[1] == '0)
                       || (lvl_q[1] == LW'(DEPTH) && lvl_q[0] == '0);
  end
  always_ff @(posedge clk) begin
    for (int k = 0; k < 2; k++)
      if (push[k]) mem_q[k][wp_q[k]] <= din[k];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        wp_q[k]  <= '0;
        rp_q[k]  <= '0;
        lvl_q[k] <= '0;
      end
      y_valid_q <= 1'b0;
      y_sum_q   <= '0;
      skew_q    <= 1'b0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (push[k]) wp_q[k] <= wp_q[k] + PW'(1);
        if (fire) rp_q[k] <= rp_q[k] + PW'(1);
        lvl_q[k] <= lvl_q[k] + LW'(push[k]) - LW'(fire);
      end
      y_valid_q <= y_valid_d;
      y_sum_q   <= y_sum_d;
      skew_q    <= skew_d;
    end
  end
`ifdef WILKINSON_COMBINER_DIFF_EN
  logic [DW:0]   dif_w;
  logic [DW-1:0] y_diff_q, y_diff_d;
  assign dif_w = {ha[DW-1], ha} - {hb[DW-1], hb};
  always_comb y_diff_d = fire ? dif_w[DW:1] : y_diff_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) y_diff_q <= '0;
    else y_diff_q <= y_diff_d;
  end
  assign bus.y_diff = y_diff_q;
`endif
  assign bus.y_valid = y_valid_q;
  assign bus.y_sum   = y_sum_q;
  assign a_level     = lvl_q[0];
  assign b_level     = lvl_q[1];
  assign skew_err    = skew_q;
endmodule

// File: tb/tb_wilkinson_combiner.sv
// tb_wilkinson_combiner: scoreboard bench; accepted pushes feed per-branch model
// queues, matched pairs produce expected outputs checked on each output handshake.
module tb_wilkinson_combiner;
  localparam int DW = 16, DEPTH = 4, LW = $clog2(DEPTH+1);
  logic          clk = 1'b0, rst_n = 1'b0;
  logic [LW-1:0] a_level, b_level;
  logic          skew_err;
  typedef struct {int s; int d;} exp_t;
  exp_t exp_q[$];
  int   qa[$], qb[$];
  int   n_chk = 0, n_pass = 0, n_out = 0;
  wilkinson_combiner_if #(.DW(DW)) bus();
  wilkinson_combiner #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .a_level(a_level), .b_level(b_level), .skew_err(skew_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic pair(input int a, input int b);
    bus.a_valid = 1'b1; bus.a_data = DW'(a);
    bus.b_valid = 1'b1; bus.b_data = DW'(b);
    tick();
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
  endtask
  // Monitor: outputs are compared before this cycle's pushes are folded into the model.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.y_valid && bus.y_ready) begin
        n_out++;
        if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("y_sum", int'($signed(bus.y_sum)), e.s);
`ifdef WILKINSON_COMBINER_DIFF_EN
          chk("y_diff", int'($signed(bus.y_diff)), e.d);
`endif
        end
      end
      if (bus.a_valid && bus.a_ready) qa.push_back(int'($signed(bus.a_data)));
      if (bus.b_valid && bus.b_ready) qb.push_back(int'($signed(bus.b_data)));
      while (qa.size() > 0 && qb.size() > 0) begin
        int a, b;
        exp_t e;
        a = qa.pop_front();
        b = qb.pop_front();
        e.s = (a + b) >>> 1;
        e.d = (a - b) >>> 1;
        exp_q.push_back(e);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int da[16], db[16];
    int ia, ib, base, hold;
    bit acc_a, acc_b;
    bus.a_valid = 1'b0; bus.b_valid = 1'b0; bus.y_ready = 1'b0;
    bus.a_data = '0; bus.b_data = '0;
    // 1: reset state
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    chk("rst_y_valid", int'(bus.y_valid), 0);
    chk("rst_a_level", int'(a_level), 0);
    chk("rst_b_level", int'(b_level), 0);
    chk("rst_a_ready", int'(bus.a_ready), 1);
    chk("rst_b_ready", int'(bus.b_ready), 1);
    chk("rst_skew", int'(skew_err), 0);
    // 2: single pair and its latency
    bus.y_ready = 1'b1;
    pair(100, -40);
    chk("lat_early_valid", int'(bus.y_valid), 0);
    tick();
    chk("lat_valid", int'(bus.y_valid), 1);
    chk("lat_sum", int'($signed(bus.y_sum)), 30);
    tick();
    chk("lat_drop_valid", int'(bus.y_valid), 0);
    chk("lat_a_level", int'(a_level), 0);
    chk("lat_b_level", int'(b_level), 0);
    // 3: rounding toward -inf and extremes
    pair(3, 0);
    pair(-3, 0);
    pair(32767, 32767);
    pair(-32768, -32768);
    pair(32767, -32768);
    repeat (4) tick();
    chk("round_drained", exp_q.size(), 0);
    // 4: skew to full on A, then B catches up
    for (int i = 1; i <= 4; i++) begin
      bus.a_valid = 1'b1; bus.a_data = DW'(i);
      tick();
    end
    bus.a_valid = 1'b0;
    chk("skew_a_level", int'(a_level), 4);
    chk("skew_a_ready", int'(bus.a_ready), 0);
    tick();
    chk("skew_set", int'(skew_err), 1);
    for (int i = 1; i <= 4; i++) begin
      bus.b_valid = 1'b1; bus.b_data = DW'(10 * i);
      tick();
    end
    bus.b_valid = 1'b0;
    repeat (3) tick();
    chk("skew_sticky", int'(skew_err), 1);
    chk("skew_drained", exp_q.size(), 0);
    chk("skew_a_empty", int'(a_level), 0);
    // 5: backpressure then release, 16 pairs
    foreach (da[i]) begin
      da[i] = int'($urandom_range(65535)) - 32768;
      db[i] = int'($urandom_range(65535)) - 32768;
    end
    ia = 0; ib = 0; base = n_out; hold = 0;
    for (int c = 0; c < 200 && (ia < 16 || ib < 16 || exp_q.size() > 0); c++) begin
      bus.a_valid = ia < 16; bus.a_data = DW'(da[ia % 16]);
      bus.b_valid = ib < 16; bus.b_data = DW'(db[ib % 16]);
      bus.y_ready = c >= 8;
      @(negedge clk);
      acc_a = bus.a_valid && bus.a_ready;
      acc_b = bus.b_valid && bus.b_ready;
      if (c == 2) hold = int'($signed(bus.y_sum));
      if (c == 7) begin
        chk("bp_y_valid", int'(bus.y_valid), 1);
        chk("bp_y_sum_stable", int'($signed(bus.y_sum)), hold);
        chk("bp_a_level", int'(a_level), 4);
        chk("bp_b_level", int'(b_level), 4);
        chk("bp_a_ready", int'(bus.a_ready), 0);
        chk("bp_b_ready", int'(bus.b_ready), 0);
      end
      tick();
      if (acc_a) ia++;
      if (acc_b) ib++;
    end
    bus.a_valid = 1'b0; bus.b_valid = 1'b0; bus.y_ready = 1'b1;
    repeat (3) tick();
    chk("bp_out_count", n_out - base, 16);
    chk("bp_drained", exp_q.size(), 0);
    // 6: async reset mid-stream
    bus.y_ready = 1'b0;
    for (int i = 0; i < 3; i++) pair(500 + i, 600 + i);
    bus.a_valid = 1'b1; bus.a_data = DW'(503);
    tick();
    bus.a_valid = 1'b0;
    chk("mid_a_level", int'(a_level), 3);
    chk("mid_b_level", int'(b_level), 2);
    chk("mid_y_valid", int'(bus.y_valid), 1);
    #2 rst_n = 1'b0;
    qa.delete(); qb.delete(); exp_q.delete();
    #1;
    chk("arst_y_valid", int'(bus.y_valid), 0);
    chk("arst_y_sum", int'($signed(bus.y_sum)), 0);
    chk("arst_a_level", int'(a_level), 0);
    chk("arst_b_level", int'(b_level), 0);
    chk("arst_skew", int'(skew_err), 0);
    tick();
    rst_n = 1'b1;
    bus.y_ready = 1'b1;
    base = n_out;
    tick();
    pair(7, 8);
    repeat (3) tick();
    chk("post_rst_out_count", n_out - base, 1);
    chk("post_rst_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
